// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver (majority-voted sampling, parity, framing
//                check) feeding a show-ahead receive FIFO with overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rxd,
    input  logic                              rd_en,
    input  logic                              clr_err,
    output logic                              rd_valid,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_ferr,
    output logic                              rd_perr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    output logic                              busy
);

    localparam int c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_fcnt_w  = $clog2(FIFO_DEPTH+1);
    localparam int c_entry_w = DATA_BITS + 2;

    localparam logic [c_cnt_w-1:0]  c_half     = c_cnt_w'(CLKS_PER_BIT / 2);
    localparam logic [c_cnt_w-1:0]  c_samp1    = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0]  c_samp3    = c_cnt_w'(CLKS_PER_BIT / 2 + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          c_last_bit = 4'(DATA_BITS - 1);
    localparam logic [c_fcnt_w-1:0] c_depth    = c_fcnt_w'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [1:0]             r_sync;
    logic                   r_rxs_prev;
    logic                   w_rxs;
    logic                   w_start_edge;

    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_samp1;
    logic                   r_samp2;
    logic                   w_mid;
    logic                   w_maj;

    logic [3:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   w_wr;

    logic [c_entry_w-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_fcnt_w-1:0]    r_count;
    logic                   r_overrun;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_ovf;
    logic [c_entry_w-1:0]   w_head;

    // Input synchroniser; idle-high reset so no spurious start edge after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxs_prev <= r_sync[1];
        end
    end

    assign w_rxs        = r_sync[1];
    assign w_start_edge = ~w_rxs & r_rxs_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_samp1 <= 1'b1;
            r_samp2 <= 1'b1;
        end else begin
            if (r_state == S_IDLE || r_cnt == c_cnt_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_samp1)
                r_samp1 <= w_rxs;
            if (r_cnt == c_half)
                r_samp2 <= w_rxs;
        end
    end

    // Third vote is the live sample on the decision cycle
    assign w_mid = (r_state != S_IDLE) && (r_cnt == c_samp3);
    assign w_maj = (r_samp1 & r_samp2) | (r_samp1 & w_rxs) | (r_samp2 & w_rxs);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge)
                    w_state_next = S_START;
            end
            S_START: begin
                if (w_mid)
                    w_state_next = w_maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_mid && r_bit_idx == c_last_bit)
                    w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_mid)
                    w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_mid) begin
                    w_wr         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_bit_idx <= '0;
                r_perr    <= 1'b0;
            end
            if (r_state == S_DATA && w_mid) begin
                r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 4'd1;
            end
            // Odd parity errs on an even ones count, even parity on an odd count
            if (r_state == S_PARITY && w_mid)
                r_perr <= (PARITY == 1) ? ~(^r_shift ^ w_maj) : (^r_shift ^ w_maj);
        end
    end

    assign w_full = (r_count == c_depth);
    assign w_pop  = rd_en && rd_valid;
    assign w_push = w_wr && (!w_full || w_pop);
    assign w_ovf  = w_wr && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {r_shift, ~w_maj, r_perr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_fcnt_w'(1);
                2'b01:   r_count <= r_count - c_fcnt_w'(1);
                default: r_count <= r_count;
            endcase
            // A fresh overrun takes priority over a simultaneous clear
            if (w_ovf)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;
        end
    end

    // Memory is not reset, so the head is masked while empty
    assign w_head     = r_mem[r_rd_ptr];
    assign rd_valid   = (r_count != '0);
    assign rd_data    = rd_valid ? w_head[c_entry_w-1:2] : '0;
    assign rd_ferr    = rd_valid ? w_head[1] : 1'b0;
    assign rd_perr    = rd_valid ? w_head[0] : 1'b0;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo (no parity and
//                even-parity instances, 16 clk per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int C_BIT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       rd_en_a = 1'b0;
    logic       rd_en_b = 1'b0;
    logic       clr_err_a = 1'b0;
    logic       clr_err_b = 1'b0;

    logic       rd_valid_a, rd_ferr_a, rd_perr_a, overrun_a, busy_a;
    logic [7:0] rd_data_a;
    logic [4:0] fifo_count_a;
    logic       rd_valid_b, rd_ferr_b, rd_perr_b, overrun_b, busy_b;
    logic [7:0] rd_data_b;
    logic [4:0] fifo_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(C_BIT), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .reset(reset), .rxd(rxd_a), .rd_en(rd_en_a), .clr_err(clr_err_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_ferr(rd_ferr_a), .rd_perr(rd_perr_a),
        .fifo_count(fifo_count_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(C_BIT), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(reset), .rxd(rxd_b), .rd_en(rd_en_b), .clr_err(clr_err_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_ferr(rd_ferr_b), .rd_perr(rd_perr_b),
        .fifo_count(fifo_count_b), .overrun(overrun_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
        repeat (C_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic stop_v,
                              input logic use_par, input logic par_v);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (use_par) send_bit(sel, par_v);
        send_bit(sel, stop_v);
        if (sel) rxd_b = 1'b1;
        else     rxd_a = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp_d, input logic exp_ferr);
        check({tag, "_valid"}, 32'(rd_valid_a), 32'd1);
        check({tag, "_data"},  32'(rd_data_a),  32'(exp_d));
        check({tag, "_ferr"},  32'(rd_ferr_a),  32'(exp_ferr));
        check({tag, "_perr"},  32'(rd_perr_a),  32'd0);
        rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
    endtask

    task automatic pop_b(input string tag, input logic [7:0] exp_d, input logic exp_perr);
        check({tag, "_data"}, 32'(rd_data_b), 32'(exp_d));
        check({tag, "_perr"}, 32'(rd_perr_b), 32'(exp_perr));
        rd_en_b = 1'b1;
        @(negedge clk);
        rd_en_b = 1'b0;
    endtask

    initial begin
        logic [7:0] t2_bytes [4];
        t2_bytes = '{8'h55, 8'hAA, 8'h21, 8'hF6};

        // T1 reset
        repeat (5) @(negedge clk);
        check("t1_rd_valid",   32'(rd_valid_a),   32'd0);
        check("t1_rd_data",    32'(rd_data_a),    32'd0);
        check("t1_rd_ferr",    32'(rd_ferr_a),    32'd0);
        check("t1_rd_perr",    32'(rd_perr_a),    32'd0);
        check("t1_fifo_count", 32'(fifo_count_a), 32'd0);
        check("t1_overrun",    32'(overrun_a),    32'd0);
        check("t1_busy",       32'(busy_a),       32'd0);
        check("t1_b_count",    32'(fifo_count_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t1_post_busy",  32'(busy_a),       32'd0);
        check("t1_post_count", 32'(fifo_count_a), 32'd0);

        // T2 back-to-back stream, no reads
        for (int i = 0; i < 4; i++) send_frame(1'b0, t2_bytes[i], 1'b1, 1'b0, 1'b0);
        check("t2_count", 32'(fifo_count_a), 32'd4);
        for (int i = 0; i < 4; i++) pop_a($sformatf("t2_pop%0d", i), t2_bytes[i], 1'b0);
        check("t2_empty", 32'(rd_valid_a), 32'd0);

        // T3 short glitch is rejected at the start-bit decision point
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_busy_high", 32'(busy_a), 32'd1);
        repeat (7) @(negedge clk);
        check("t3_busy_before", 32'(busy_a), 32'd1);
        @(negedge clk);
        check("t3_busy_fall", 32'(busy_a), 32'd0);
        repeat (20) @(negedge clk);
        check("t3_count", 32'(fifo_count_a), 32'd0);
        check("t3_busy_idle", 32'(busy_a), 32'd0);

        // T4 framing error followed by a break, then a clean frame
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 8'h68 >> i);
        send_bit(1'b0, 1'b0);
        repeat (3 * C_BIT) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * C_BIT) @(negedge clk);
        check("t4_break_count", 32'(fifo_count_a), 32'd1);
        send_frame(1'b0, 8'h0B, 1'b1, 1'b0, 1'b0);
        check("t4_count", 32'(fifo_count_a), 32'd2);
        pop_a("t4_ferr_byte", 8'h68, 1'b1);
        pop_a("t4_clean_byte", 8'h0B, 1'b0);

        // T5 even parity
        send_frame(1'b1, 8'h0B, 1'b1, 1'b1, 1'b1);
        send_frame(1'b1, 8'h0B, 1'b1, 1'b1, 1'b0);
        check("t5_count", 32'(fifo_count_b), 32'd2);
        pop_b("t5_good", 8'h0B, 1'b0);
        pop_b("t5_bad",  8'h0B, 1'b1);

        // T6 overrun
        for (int i = 0; i <= 16; i++) begin
            send_frame(1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 15) check("t6_no_ovr_at_full", 32'(overrun_a), 32'd0);
        end
        check("t6_count", 32'(fifo_count_a), 32'd16);
        check("t6_overrun", 32'(overrun_a), 32'd1);
        for (int i = 0; i < 16; i++) pop_a($sformatf("t6_pop%0d", i), 8'(i), 1'b0);
        check("t6_ovr_sticky", 32'(overrun_a), 32'd1);
        clr_err_a = 1'b1;
        @(negedge clk);
        clr_err_a = 1'b0;
        check("t6_ovr_clear", 32'(overrun_a), 32'd0);

        // Full FIFO with a pop on the write cycle: both happen, no overrun
        for (int i = 0; i < 16; i++) send_frame(1'b0, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        check("t6_refill", 32'(fifo_count_a), 32'd16);
        fork
            send_frame(1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
            begin
                repeat (156) @(negedge clk);
                rd_en_a = 1'b1;
                @(negedge clk);
                rd_en_a = 1'b0;
            end
        join
        check("t6_rw_count", 32'(fifo_count_a), 32'd16);
        check("t6_rw_overrun", 32'(overrun_a), 32'd0);
        for (int i = 0; i < 16; i++) pop_a($sformatf("t6_rw_pop%0d", i), 8'(8'h21 + i), 1'b0);
        check("t6_drained", 32'(fifo_count_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
